// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter that shares one system bus between up to eight masters.
// It tracks each tenure from grant, through begin/end of transaction, to a
// one-cycle release. It recovers the bus when a master abandons its grant,
// when a slave reports an error, or (optionally) when a transfer hangs.
//
// Optional feature macro: BUS_ARBITER_TIMEOUT_EN
//   defined   : 16-bit BUSY timeout counter; errorOUT pulses on timeout.
//   undefined : no counter; errorOUT tied low; TIMEOUT_CYCLES is ignored.
//
// Ports:
//   clock               in   system clock, rising edge
//   reset               in   synchronous active-high reset
//   request             in   per-master level-held bus request
//   granted             out  one-hot registered grant
//   begin_transactionIN in   begin-transaction strobe from the owner
//   end_transactionIN   in   end-transaction strobe
//   errorIN             in   bus error from any slave
//   errorOUT            out  arbiter timeout error, one-cycle pulse
//   owner               out  index of current/last granted master
//   bus_idle            out  high while the arbiter is in IDLE
module bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] granted,
  input  logic                   begin_transactionIN,
  input  logic                   end_transactionIN,
  input  logic                   errorIN,
  output logic                   errorOUT,
  output logic [2:0]             owner,
  output logic                   bus_idle
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [2:0] OWNER_RST = 3'(NUM_MASTERS - 1);

  state_t                   state_q, state_d;
  logic [2:0]               owner_q, owner_d;
  logic [NUM_MASTERS-1:0]   granted_q, granted_d;
  logic [7:0]               req_ext_s;
  logic                     win_found_s;
  logic [2:0]               win_idx_s;
  logic                     timeout_s;

  // Zero-extend so a 3-bit index is always legal regardless of NUM_MASTERS.
  assign req_ext_s = 8'(request);

  // Round-robin search: start just after the last owner, ascending with wrap.
  always_comb begin
    int cand;
    win_found_s = 1'b0;
    win_idx_s   = owner_q;
    cand        = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = (int'(owner_q) + i) % NUM_MASTERS;
      if (!win_found_s && req_ext_s[3'(cand)]) begin
        win_found_s = 1'b1;
        win_idx_s   = 3'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        error_q, error_d;

  assign timeout_s = (state_q == S_BUSY) && (cnt_q == TIMEOUT_LAST);

  // Timeout counter: counts only while BUSY, saturates instead of wrapping.
  always_comb begin
    cnt_d = 16'd0;
    if (state_q == S_BUSY && state_d == S_BUSY) begin
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = 16'd0;
    end
  end

  // Error pulse only for a genuine timeout; a slave error or a coincident end wins.
  always_comb begin
    error_d = 1'b0;
    if (timeout_s && !errorIN && !end_transactionIN) begin
      error_d = 1'b1;
    end else begin
      error_d = 1'b0;
    end
  end

  // Counter and error flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= 16'd0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign errorOUT = error_q;
`else
  assign timeout_s = 1'b0;
  assign errorOUT  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= OWNER_RST;
      granted_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      granted_q <= granted_d;
    end
  end

  // Next-state logic; errorIN overrides everything in GRANT and BUSY.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          state_d = S_GRANT;
          owner_d = win_idx_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // begin beats a dropped request: masters drop request while handshaking.
        if (errorIN) begin
          state_d = S_RELEASE;
        end else if (begin_transactionIN) begin
          state_d = S_BUSY;
        end else if (!req_ext_s[owner_q]) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_GRANT;
        end
      end
      S_BUSY: begin
        if (errorIN || end_transactionIN || timeout_s) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from next state so the grant flop lines up with the state flop.
  always_comb begin
    logic [7:0] onehot;
    onehot    = 8'd1 << owner_d;
    granted_d = '0;
    if (state_d == S_GRANT || state_d == S_BUSY) begin
      granted_d = onehot[NUM_MASTERS-1:0];
    end else begin
      granted_d = '0;
    end
  end

  assign granted  = granted_q;
  assign owner    = owner_q;
  assign bus_idle = (state_q == S_IDLE);

endmodule
